// File: rtl/reservation_station_pkg.sv
// Shared widths, entry layout and the operand wakeup helper for the reservation station.
package reservation_station_pkg;

    localparam int unsigned RS_SIZE   = 16;
    localparam int unsigned RS_POS_W  = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ROB_POS_W = 4;
    localparam int unsigned ROB_ID_W  = 5;
    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned FUNCT3_W  = 3;
    localparam int unsigned CNT_W     = RS_POS_W + 2;

    typedef logic [CNT_W-1:0] cnt_t;

    // q[4] marks a pending operand, q[3:0] is the producing ROB slot.
    typedef struct packed {
        logic [ROB_ID_W-1:0] q;
        logic [DATA_W-1:0]   v;
    } opnd_t;

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [FUNCT3_W-1:0]  funct3;
        logic                 funct7;
        opnd_t                j;
        opnd_t                k;
        logic [DATA_W-1:0]    imm;
        logic [DATA_W-1:0]    pc;
        logic [ROB_POS_W-1:0] rob_pos;
    } rs_entry_t;

    function automatic opnd_t wake(input opnd_t o,
                                   input logic a_en, input logic [ROB_POS_W-1:0] a_pos,
                                   input logic [DATA_W-1:0] a_val,
                                   input logic l_en, input logic [ROB_POS_W-1:0] l_pos,
                                   input logic [DATA_W-1:0] l_val);
        opnd_t r;
        r = o;
        if (o.q[ROB_ID_W-1]) begin
            if (a_en && o.q[ROB_POS_W-1:0] == a_pos) begin
                r.q = '0;
                r.v = a_val;
            end else if (l_en && o.q[ROB_POS_W-1:0] == l_pos) begin
                r.q = '0;
                r.v = l_val;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Decoder issue, result broadcast and ALU dispatch signals of the reservation station.
interface reservation_station_if;
    import reservation_station_pkg::*;

    logic                 issue;
    logic                 rs_en;
    logic [ROB_POS_W-1:0] rob_pos;
    logic [OPCODE_W-1:0]  opcode;
    logic [FUNCT3_W-1:0]  funct3;
    logic                 funct7;
    logic [DATA_W-1:0]    rs1_val;
    logic [DATA_W-1:0]    rs2_val;
    logic [ROB_ID_W-1:0]  rs1_rob_id;
    logic [ROB_ID_W-1:0]  rs2_rob_id;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    pc;
    logic                 rs_nxt_full;
    logic                 alu_result;
    logic [ROB_POS_W-1:0] alu_result_rob_pos;
    logic [DATA_W-1:0]    alu_result_val;
    logic                 lsb_result;
    logic [ROB_POS_W-1:0] lsb_result_rob_pos;
    logic [DATA_W-1:0]    lsb_result_val;
    logic                 alu_en;
    logic [OPCODE_W-1:0]  alu_opcode;
    logic [FUNCT3_W-1:0]  alu_funct3;
    logic                 alu_funct7;
    logic [DATA_W-1:0]    alu_val1;
    logic [DATA_W-1:0]    alu_val2;
    logic [DATA_W-1:0]    alu_imm;
    logic [DATA_W-1:0]    alu_pc;
    logic [ROB_POS_W-1:0] alu_rob_pos;

    modport master (
        output issue, rs_en, rob_pos, opcode, funct3, funct7, rs1_val, rs2_val,
               rs1_rob_id, rs2_rob_id, imm, pc, alu_result, alu_result_rob_pos,
               alu_result_val, lsb_result, lsb_result_rob_pos, lsb_result_val,
        input  rs_nxt_full, alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1,
               alu_val2, alu_imm, alu_pc, alu_rob_pos
    );

    modport slave (
        input  issue, rs_en, rob_pos, opcode, funct3, funct7, rs1_val, rs2_val,
               rs1_rob_id, rs2_rob_id, imm, pc, alu_result, alu_result_rob_pos,
               alu_result_val, lsb_result, lsb_result_rob_pos, lsb_result_val,
        output rs_nxt_full, alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1,
               alu_val2, alu_imm, alu_pc, alu_rob_pos
    );

endinterface

// File: rtl/reservation_station_select.sv
// Lowest-index priority encoder: flags any request and returns the lowest set index.
module reservation_station_select #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic [N-1:0] req,
    output logic         vld,
    output logic [W-1:0] idx
);

    always_comb begin
        vld = |req;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/reservation_station.sv
// ALU-class reservation station: buffers issued instructions, captures broadcast
// operands and dispatches the lowest-index ready entry to the ALU each cycle.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 rollback,
    reservation_station_if.slave bus
);

    logic [RS_SIZE-1:0]  busy_q, busy_d, ready;
    rs_entry_t           ent_q [RS_SIZE];
    rs_entry_t           ent_d [RS_SIZE];
    rs_entry_t           new_ent;
    opnd_t               j_in, k_in;
    logic                free_vld, ready_vld, do_issue;
    logic [RS_POS_W-1:0] free_idx, ready_idx;
    cnt_t                busy_cnt, nxt_cnt;

    logic                 alu_en_q;
    logic [OPCODE_W-1:0]  alu_opcode_q;
    logic [FUNCT3_W-1:0]  alu_funct3_q;
    logic                 alu_funct7_q;
    logic [DATA_W-1:0]    alu_val1_q, alu_val2_q, alu_imm_q, alu_pc_q;
    logic [ROB_POS_W-1:0] alu_rob_pos_q;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = busy_q[i] && (ent_q[i].j.q == '0) && (ent_q[i].k.q == '0);
        end
    end

    reservation_station_select #(.N(RS_SIZE), .W(RS_POS_W)) u_free_sel (
        .req (~busy_q),
        .vld (free_vld),
        .idx (free_idx)
    );

    reservation_station_select #(.N(RS_SIZE), .W(RS_POS_W)) u_ready_sel (
        .req (ready),
        .vld (ready_vld),
        .idx (ready_idx)
    );

    assign do_issue = bus.issue && bus.rs_en && free_vld;

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < RS_SIZE; i++) busy_cnt = busy_cnt + cnt_t'(busy_q[i]);
        nxt_cnt = busy_cnt + cnt_t'(bus.issue && bus.rs_en) - cnt_t'(ready_vld);
    end

    assign bus.rs_nxt_full = (nxt_cnt == cnt_t'(RS_SIZE));

    // Incoming operands see same-cycle broadcasts so they never miss a wakeup.
    always_comb begin
        j_in.q = bus.rs1_rob_id;
        j_in.v = bus.rs1_val;
        k_in.q = bus.rs2_rob_id;
        k_in.v = bus.rs2_val;
        new_ent.opcode  = bus.opcode;
        new_ent.funct3  = bus.funct3;
        new_ent.funct7  = bus.funct7;
        new_ent.j       = wake(j_in, bus.alu_result, bus.alu_result_rob_pos, bus.alu_result_val,
                               bus.lsb_result, bus.lsb_result_rob_pos, bus.lsb_result_val);
        new_ent.k       = wake(k_in, bus.alu_result, bus.alu_result_rob_pos, bus.alu_result_val,
                               bus.lsb_result, bus.lsb_result_rob_pos, bus.lsb_result_val);
        new_ent.imm     = bus.imm;
        new_ent.pc      = bus.pc;
        new_ent.rob_pos = bus.rob_pos;
    end

    always_comb begin
        busy_d = busy_q;
        ent_d  = ent_q;
        if (rollback) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i]) begin
                    ent_d[i].j = wake(ent_q[i].j, bus.alu_result, bus.alu_result_rob_pos,
                                      bus.alu_result_val, bus.lsb_result,
                                      bus.lsb_result_rob_pos, bus.lsb_result_val);
                    ent_d[i].k = wake(ent_q[i].k, bus.alu_result, bus.alu_result_rob_pos,
                                      bus.alu_result_val, bus.lsb_result,
                                      bus.lsb_result_rob_pos, bus.lsb_result_val);
                end
            end
            if (ready_vld) busy_d[ready_idx] = 1'b0;
            if (do_issue) begin
                busy_d[free_idx] = 1'b1;
                ent_d[free_idx]  = new_ent;
            end
        end
    end

    // Payloads are only meaningful while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        if (rdy) ent_q <= ent_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q        <= '0;
            alu_en_q      <= 1'b0;
            alu_opcode_q  <= '0;
            alu_funct3_q  <= '0;
            alu_funct7_q  <= 1'b0;
            alu_val1_q    <= '0;
            alu_val2_q    <= '0;
            alu_imm_q     <= '0;
            alu_pc_q      <= '0;
            alu_rob_pos_q <= '0;
        end else if (rdy) begin
            busy_q <= busy_d;
            if (rollback) begin
                alu_en_q <= 1'b0;
            end else begin
                alu_en_q <= ready_vld;
                if (ready_vld) begin
                    alu_opcode_q  <= ent_q[ready_idx].opcode;
                    alu_funct3_q  <= ent_q[ready_idx].funct3;
                    alu_funct7_q  <= ent_q[ready_idx].funct7;
                    alu_val1_q    <= ent_q[ready_idx].j.v;
                    alu_val2_q    <= ent_q[ready_idx].k.v;
                    alu_imm_q     <= ent_q[ready_idx].imm;
                    alu_pc_q      <= ent_q[ready_idx].pc;
                    alu_rob_pos_q <= ent_q[ready_idx].rob_pos;
                end
            end
        end
    end

    assign bus.alu_en      = alu_en_q;
    assign bus.alu_opcode  = alu_opcode_q;
    assign bus.alu_funct3  = alu_funct3_q;
    assign bus.alu_funct7  = alu_funct7_q;
    assign bus.alu_val1    = alu_val1_q;
    assign bus.alu_val2    = alu_val2_q;
    assign bus.alu_imm     = alu_imm_q;
    assign bus.alu_pc      = alu_pc_q;
    assign bus.alu_rob_pos = alu_rob_pos_q;

    // The decoder must honour rs_nxt_full; an issue into a full station is lost.
    a_no_issue_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        (rdy && !rollback && bus.issue && bus.rs_en) |-> free_vld);

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station; a monitor checks every ALU dispatch against a queue.
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam logic [6:0] OP_ARITH  = 7'b0110011;
    localparam logic [6:0] OP_ARITHI = 7'b0010011;
    localparam logic [6:0] OP_BR     = 7'b1100011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b1;
    logic rollback = 1'b0;

    reservation_station_if bus ();

    reservation_station dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rdy      (rdy),
        .rollback (rollback),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [3:0]  rob;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] v1, v2, imm, pc;
        int          edge_no;
    } exp_t;

    exp_t sb[$];
    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue = 1'b0;
        bus.rs_en = 1'b0;
        bus.alu_result = 1'b0;
        bus.lsb_result = 1'b0;
        rollback = 1'b0;
    endtask

    task automatic set_issue(input logic [3:0] rob, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic [31:0] v1, input logic [4:0] q1,
                             input logic [31:0] v2, input logic [4:0] q2,
                             input logic [31:0] imm, input logic [31:0] pc);
        bus.issue = 1'b1;
        bus.rs_en = 1'b1;
        bus.rob_pos = rob;
        bus.opcode = op;
        bus.funct3 = f3;
        bus.funct7 = f7;
        bus.rs1_val = v1;
        bus.rs1_rob_id = q1;
        bus.rs2_val = v2;
        bus.rs2_rob_id = q2;
        bus.imm = imm;
        bus.pc = pc;
    endtask

    task automatic expect_disp(input logic [3:0] rob, input logic [6:0] op, input logic [2:0] f3,
                               input logic f7, input logic [31:0] v1, input logic [31:0] v2,
                               input logic [31:0] imm, input logic [31:0] pc, input int e);
        exp_t x;
        x.rob = rob; x.op = op; x.f3 = f3; x.f7 = f7;
        x.v1 = v1; x.v2 = v2; x.imm = imm; x.pc = pc; x.edge_no = e;
        sb.push_back(x);
    endtask

    task automatic bcast_alu(input logic [3:0] pos, input logic [31:0] val);
        bus.alu_result = 1'b1;
        bus.alu_result_rob_pos = pos;
        bus.alu_result_val = val;
    endtask

    initial begin
        bus.rob_pos = '0; bus.opcode = '0; bus.funct3 = '0; bus.funct7 = 1'b0;
        bus.rs1_val = '0; bus.rs2_val = '0; bus.rs1_rob_id = '0; bus.rs2_rob_id = '0;
        bus.imm = '0; bus.pc = '0;
        bus.alu_result_rob_pos = '0; bus.alu_result_val = '0;
        bus.lsb_result_rob_pos = '0; bus.lsb_result_val = '0;
        idle();

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (rst_n && bus.alu_en) begin
                        if (sb.size() == 0) begin
                            compared++;
                            mismatched++;
                            $display("FAIL unexpected_dispatch: got rob %0d expected none",
                                     bus.alu_rob_pos);
                        end else begin
                            e = sb.pop_front();
                            check("disp_edge", edge_cnt, e.edge_no);
                            check("disp_rob", 32'(bus.alu_rob_pos), 32'(e.rob));
                            check("disp_val1", bus.alu_val1, e.v1);
                            check("disp_val2", bus.alu_val2, e.v2);
                            check("disp_ctrl", 32'({bus.alu_opcode, bus.alu_funct3, bus.alu_funct7}),
                                  32'({e.op, e.f3, e.f7}));
                            check("disp_imm", bus.alu_imm, e.imm);
                            check("disp_pc", bus.alu_pc, e.pc);
                        end
                    end
                end
            end
        join_none

        // Reset values
        #12;
        check("reset_alu_en", 32'(bus.alu_en), 0);
        check("reset_alu_val1", bus.alu_val1, 0);
        check("reset_nxt_full", 32'(bus.rs_nxt_full), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Both operands ready at issue
        set_issue(4'd1, OP_ARITH, 3'b000, 1'b0, 32'd5, 5'd0, 32'd7, 5'd0, 32'd0, 32'h1000);
        #1 check("nxt_full_single", 32'(bus.rs_nxt_full), 0);
        step();
        expect_disp(4'd1, OP_ARITH, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 32'h1000, edge_cnt + 1);
        idle();
        step(); step();

        // rs1 waits on ROB 3, woken by the ALU two cycles later
        set_issue(4'd2, OP_ARITH, 3'b000, 1'b1, 32'hdead, 5'b1_0011, 32'h22, 5'd0, 32'd0,
                  32'h1004);
        step();
        idle();
        step();
        bcast_alu(4'd3, 32'h1234);
        step();
        expect_disp(4'd2, OP_ARITH, 3'b000, 1'b1, 32'h1234, 32'h22, 32'd0, 32'h1004,
                    edge_cnt + 1);
        idle();
        step(); step();

        // Same-cycle LSB broadcast captured at issue
        set_issue(4'd4, OP_ARITHI, 3'b111, 1'b0, 32'h0, 5'b1_0010, 32'h0, 5'd0, 32'hff,
                  32'h1008);
        bus.lsb_result = 1'b1;
        bus.lsb_result_rob_pos = 4'd2;
        bus.lsb_result_val = 32'haa;
        step();
        expect_disp(4'd4, OP_ARITHI, 3'b111, 1'b0, 32'haa, 32'h0, 32'hff, 32'h1008, edge_cnt + 1);
        idle();
        step(); step();

        // ALU and LSB wake different operands of one entry in the same cycle
        set_issue(4'd6, OP_BR, 3'b001, 1'b0, 32'h0, 5'b1_0101, 32'h0, 5'b1_0110, 32'h40,
                  32'h100c);
        step();
        idle();
        bcast_alu(4'd5, 32'h50);
        bus.lsb_result = 1'b1;
        bus.lsb_result_rob_pos = 4'd6;
        bus.lsb_result_val = 32'h60;
        step();
        expect_disp(4'd6, OP_BR, 3'b001, 1'b0, 32'h50, 32'h60, 32'h40, 32'h100c, edge_cnt + 1);
        idle();
        step(); step();

        // Fill all 16 entries waiting on ROB 9
        for (int i = 0; i < 16; i++) begin
            set_issue(4'(i), OP_ARITH, 3'b000, 1'b0, 32'h0, 5'b1_1001, 32'(i * 3), 5'd0,
                      32'(i), 32'(32'h2000 + 4 * i));
            #1;
            if (i == 14) check("nxt_full_at_15", 32'(bus.rs_nxt_full), 0);
            if (i == 15) check("nxt_full_at_16", 32'(bus.rs_nxt_full), 1);
            step();
        end
        idle();
        #1 check("nxt_full_held", 32'(bus.rs_nxt_full), 1);
        step();
        bcast_alu(4'd9, 32'h99);
        step();
        for (int i = 0; i < 16; i++) begin
            expect_disp(4'(i), OP_ARITH, 3'b000, 1'b0, 32'h99, 32'(i * 3), 32'(i),
                        32'(32'h2000 + 4 * i), edge_cnt + 1 + i);
        end
        idle();
        #1 check("nxt_full_drop", 32'(bus.rs_nxt_full), 0);
        for (int i = 0; i < 17; i++) step();

        // rdy low freezes state and drops issues
        set_issue(4'd7, OP_ARITH, 3'b100, 1'b0, 32'h3, 5'd0, 32'h4, 5'd0, 32'd0, 32'h3000);
        step();
        expect_disp(4'd7, OP_ARITH, 3'b100, 1'b0, 32'h3, 32'h4, 32'd0, 32'h3000, edge_cnt + 3);
        rdy = 1'b0;
        set_issue(4'd8, OP_ARITH, 3'b000, 1'b0, 32'h1, 5'd0, 32'h1, 5'd0, 32'd0, 32'h3004);
        step(); step();
        check("frozen_alu_en", 32'(bus.alu_en), 0);
        idle();
        rdy = 1'b1;
        step(); step(); step();

        // Rollback with 4 busy entries (one ready) and a same-cycle issue
        for (int i = 0; i < 3; i++) begin
            set_issue(4'(i), OP_ARITH, 3'b000, 1'b0, 32'h0, 5'b1_0111, 32'h0, 5'd0, 32'd0,
                      32'h4000);
            step();
        end
        set_issue(4'd3, OP_ARITH, 3'b000, 1'b0, 32'h1, 5'd0, 32'h2, 5'd0, 32'd0, 32'h4010);
        step();
        set_issue(4'd4, OP_ARITH, 3'b000, 1'b0, 32'h1, 5'd0, 32'h2, 5'd0, 32'd0, 32'h4014);
        rollback = 1'b1;
        step();
        idle();
        check("rollback_alu_en", 32'(bus.alu_en), 0);
        check("rollback_nxt_full", 32'(bus.rs_nxt_full), 0);
        bcast_alu(4'd7, 32'h77);
        step();
        idle();
        step(); step(); step();

        // Asynchronous reset while a dispatch is presented and 3 entries wait
        for (int i = 0; i < 3; i++) begin
            set_issue(4'(i + 8), OP_ARITH, 3'b000, 1'b0, 32'h0, 5'b1_1100, 32'h0, 5'd0, 32'd0,
                      32'h5000);
            step();
        end
        set_issue(4'd11, OP_ARITH, 3'b000, 1'b0, 32'h9, 5'd0, 32'h8, 5'd0, 32'd0, 32'h500c);
        step();
        idle();
        step();
        check("pre_reset_alu_en", 32'(bus.alu_en), 1);
        check("pre_reset_rob", 32'(bus.alu_rob_pos), 11);
        rst_n = 1'b0;
        #1;
        check("async_reset_alu_en", 32'(bus.alu_en), 0);
        check("async_reset_rob", 32'(bus.alu_rob_pos), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_reset_nxt_full", 32'(bus.rs_nxt_full), 0);
        step();
        bcast_alu(4'd12, 32'hcc);
        step();
        idle();
        step(); step(); step();

        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Receives ALU-class instructions (ARITH, ARITHI, BR, JALR) issued by the decoder.
- Holds each instruction until both operands are available, capturing values from the ALU and LSB result broadcasts.
- Dispatches one ready instruction per cycle to the ALU.
- Forms the responder side of the decoder issue interface and drives the decoder's rs_nxt_full back-pressure.

Parameters:
- RS_SIZE, 16, number of entries (power of two).
- RS_POS_W, 4, log2(RS_SIZE).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rdy  in  1  global enable; low freezes all state.
- rollback  in  1  flush on misprediction.
- issue  in  1  decoder issue valid.
- rs_en  in  1  instruction targets this block; write occurs only when issue && rs_en.
- rob_pos  in  4  ROB slot of the issued instruction.
- opcode  in  7  issued opcode.
- funct3  in  3  issued funct3.
- funct7  in  1  issued funct7 (inst[30]).
- rs1_val, rs2_val  in  32 each  operand values.
- rs1_rob_id, rs2_rob_id  in  5 each  bit4 = pending, [3:0] = producing ROB pos; 0 means the value is valid.
- imm  in  32  immediate.
- pc  in  32  instruction address.
- rs_nxt_full  out  1  no free slot after this edge (combinational).
- alu_result  in  1  ALU broadcast valid.
- alu_result_rob_pos  in  4  ALU broadcast ROB pos.
- alu_result_val  in  32  ALU broadcast value.
- lsb_result  in  1  LSB broadcast valid.
- lsb_result_rob_pos  in  4  LSB broadcast ROB pos.
- lsb_result_val  in  32  LSB broadcast value.
- alu_en  out  1  dispatch valid (registered).
- alu_opcode  out  7  dispatched opcode (registered).
- alu_funct3  out  3  dispatched funct3 (registered).
- alu_funct7  out  1  dispatched funct7 (registered).
- alu_val1, alu_val2  out  32 each  dispatched operands (registered).
- alu_imm  out  32  dispatched immediate (registered).
- alu_pc  out  32  dispatched pc (registered).
- alu_rob_pos  out  4  dispatched ROB pos (registered).

Behaviour:
- Entry fields: busy, opcode, funct3, funct7, vj, qj, vk, qk, imm, pc, rob_pos.
- Reset (rst_n low, asynchronous):
  - All busy bits cleared.
  - alu_en = 0; all other alu_* outputs = 0.
  - Entry payloads need no reset.
- Priority per edge: reset > !rdy (hold everything) > rollback > normal operation.
- Rollback:
  - All busy bits cleared and alu_en <= 0.
  - Same-cycle issue and broadcasts are ignored.
- Issue:
  - When issue && rs_en, the instruction is written into the lowest-index non-busy entry.
  - A same-cycle broadcast whose pos matches an incoming pending qj/qk is applied to the written entry: v <= result_val, q <= 0.
- Wakeup:
  - For each busy entry with q[4] = 1 and q[3:0] equal to alu_result_rob_pos (when alu_result) or lsb_result_rob_pos (when lsb_result): v <= value, q <= 0.
  - ALU and LSB broadcasts in the same cycle are both applied, including to different operands of one entry.
- Ready: busy && qj == 0 && qk == 0, evaluated on registered state.
- Dispatch:
  - The lowest-index ready entry is selected.
  - At the edge: alu_en <= 1, alu_* <= entry fields (val1 = vj, val2 = vk), and the entry's busy bit is cleared.
  - With no ready entry: alu_en <= 0; other alu_* outputs hold.
- Latency: an issue written at edge E can dispatch at E+1, with alu_en high in the cycle after E+1. A wakeup at edge W allows dispatch at W+1.
- rs_nxt_full: nxt_cnt = busy_cnt + (issue && rs_en) - dispatching_now; rs_nxt_full = (nxt_cnt == RS_SIZE). It is computed combinationally every cycle, including when rdy is low.
- Full-state issue: an issue arriving while all entries are busy is a protocol violation; it is dropped, and an assertion flags it.
- Broadcast to a non-pending operand: ignored (q == 0 never matches because bit4 is required).

Decomposition:
- Add to macros.v:
  - RS_SIZE
  - RS_POS_WID
  - RS_ENTRY layout widths
  - Reuse of DATA_WID, ROB_POS_WID, ROB_ID_WID, OPCODE_WID, FUNCT3_WID
- Sub-module rs_select: a parameterised lowest-index priority encoder (valid + index), instantiated twice, once for the free slot and once for the ready entry.

Test Plan:
- Reset mid-operation with 3 busy entries, rst_n low → alu_en = 0 immediately; after release rs_nxt_full = 0 and no dispatch occurs.
- Issue ADD at edge 1 with rs1_val = 5, rs2_val = 7, both rob_id = 0 → alu_en = 1 after edge 2, alu_val1 = 5, alu_val2 = 7, alu_rob_pos matches the issue.
- Issue with rs1_rob_id = 5'b1_0011; alu_result pos = 3, val = 0x1234 two cycles later → dispatch one edge after the broadcast with alu_val1 = 0x1234.
- Issue with qj pos 2 while lsb_result pos 2, val = 0xAA in the same cycle → entry stored ready; dispatches next edge with val1 = 0xAA.
- Fill 16 entries that all wait on pos 9 → rs_nxt_full = 1 while issuing the 16th; the ALU broadcast for pos 9 then produces 16 dispatches in index order on consecutive cycles, and rs_nxt_full drops on the first dispatch.
- With 4 busy entries and rollback high in the same cycle as an issue → all busy bits cleared, alu_en = 0 next cycle, and no later dispatch occurs.
